sobel_mag_scale: RTL

Pipelined gradient-magnitude stage of the Sobel datapath. It takes signed horizontal/vertical gradients (Gx, Gy) from the convolution stage and computes the L1 magnitude |Gx|+|Gy|. It scales that magnitude by a per-pixel logical right shift, performed through the existing `shift` block, then saturates to the output pixel width. An optional threshold binarizes the result. It sits between the 3x3 convolution stage and the output pixel writer, and carries a valid/ready stream with an end-of-line sideband.

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/shift.sv | 37 +++
 rtl/sobel_mag_scale.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared constants and types for the Sobel datapath.
//   DEFAULT_IN_W / DEFAULT_OUT_W : default gradient and output pixel widths
//   SHIFT_OP_*                   : op encodings understood by the shift block
//   mag_cfg_t                    : per-pixel sideband carried through the
//                                  magnitude pipeline (sized for the defaults)
package sobel_pkg;

  localparam int DEFAULT_IN_W  = 11;
  localparam int DEFAULT_OUT_W = 8;
  localparam int MAG_SHAMT_W   = $clog2(DEFAULT_IN_W + 1);

  localparam logic [1:0] SHIFT_OP_SLL  = 2'b00;
  localparam logic [1:0] SHIFT_OP_SRL  = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRA  = 2'b10;
  localparam logic [1:0] SHIFT_OP_PASS = 2'b11;

  typedef struct packed {
    logic                     last;
    logic [MAG_SHAMT_W-1:0]   shamt;
    logic                     bin_en;
    logic [DEFAULT_OUT_W-1:0] thresh;
  } mag_cfg_t;

endpackage

// File: rtl/shift.sv
// shift: combinational barrel shifter shared across the datapath.
//   data_i  [WIDTH_P]    : operand
//   shamt_i [SHAMT_W_P]  : shift amount
//   op_i    [2]          : SLL / SRL / SRA / pass-through
//   data_o  [WIDTH_P]    : result
// Shift amounts at or beyond WIDTH_P fully shift the operand out
// (zero for logical shifts, sign fill for SRA).
module shift
  import sobel_pkg::*;
#(
  parameter int WIDTH_P   = 12,
  parameter int SHAMT_W_P = $clog2(WIDTH_P)
) (
  input  logic [WIDTH_P-1:0]   data_i,
  input  logic [SHAMT_W_P-1:0] shamt_i,
  input  logic [1:0]           op_i,
  output logic [WIDTH_P-1:0]   data_o
);

  // SHAMT_W_P+1 bits always hold WIDTH_P since 2^SHAMT_W_P >= WIDTH_P.
  localparam logic [SHAMT_W_P:0] LIMIT = (SHAMT_W_P + 1)'(WIDTH_P);

  logic out_of_range;
  assign out_of_range = ({1'b0, shamt_i} >= LIMIT);

  always_comb begin
    data_o = data_i;
    unique case (op_i)
      SHIFT_OP_SLL: data_o = out_of_range ? '0 : (data_i << shamt_i);
      SHIFT_OP_SRL: data_o = out_of_range ? '0 : (data_i >> shamt_i);
      SHIFT_OP_SRA: data_o = out_of_range ? {WIDTH_P{data_i[WIDTH_P-1]}}
                                          : WIDTH_P'($signed(data_i) >>> shamt_i);
      default:      data_o = data_i;
    endcase
  end

endmodule

// File: rtl/sobel_mag_scale.sv
// sobel_mag_scale: L1 gradient magnitude, per-pixel right-shift scaling,
// saturation to OUT_W and optional binarization, as a 3-stage valid/ready
// pipeline with an end-of-line sideband.
//   clk_i, rst_ni              : clock, synchronous active-low reset
//   valid_i / ready_o          : input handshake
//   gx_i, gy_i                 : signed gradients
//   last_i, shamt_i,
//   bin_en_i, thresh_i         : per-pixel sideband, travels with the pixel
//   valid_o / ready_i          : output handshake
//   pix_o, last_o              : scaled pixel and end-of-line flag
// The whole pipe advances on one enable (no bubble collapsing), so a stall
// at the output reaches ready_o combinationally in the same cycle.
// The carried config struct is sized by the sobel_pkg defaults; overriding
// IN_W/OUT_W requires matching package defaults.
module sobel_mag_scale
  import sobel_pkg::*;
#(
  parameter int IN_W  = DEFAULT_IN_W,
  parameter int OUT_W = DEFAULT_OUT_W,
  localparam int SUM_W   = IN_W + 1,
  localparam int SHAMT_W = $clog2(SUM_W)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic signed [IN_W-1:0] gx_i,
  input  logic signed [IN_W-1:0] gy_i,
  input  logic                   last_i,
  input  logic [SHAMT_W-1:0]     shamt_i,
  input  logic                   bin_en_i,
  input  logic [OUT_W-1:0]       thresh_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [OUT_W-1:0]       pix_o,
  output logic                   last_o
);

  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'((1 << OUT_W) - 1);

  logic en;
  assign en      = ~valid_o | ready_i;
  assign ready_o = en;

  // Two's-complement negate in IN_W unsigned bits: -2^(IN_W-1) maps to
  // 2^(IN_W-1), which fits without wrapping.
  logic [IN_W-1:0] abs_x, abs_y;
  always_comb begin
    abs_x = gx_i[IN_W-1] ? (~$unsigned(gx_i) + IN_W'(1)) : $unsigned(gx_i);
    abs_y = gy_i[IN_W-1] ? (~$unsigned(gy_i) + IN_W'(1)) : $unsigned(gy_i);
  end

  // S1
  logic            s1_valid;
  logic [IN_W-1:0] s1_absx, s1_absy;
  mag_cfg_t        s1_cfg;

  // S2
  logic             s2_valid;
  logic [SUM_W-1:0] s2_scaled;
  logic             s2_last;
  logic             s2_bin_en;
  logic [OUT_W-1:0] s2_thresh;

  logic [SUM_W-1:0] sum, scaled;
  assign sum = {1'b0, s1_absx} + {1'b0, s1_absy};

  shift #(
    .WIDTH_P   (SUM_W),
    .SHAMT_W_P (SHAMT_W)
  ) u_shift (
    .data_i  (sum),
    .shamt_i (SHAMT_W'(s1_cfg.shamt)),
    .op_i    (SHIFT_OP_SRL),
    .data_o  (scaled)
  );

  // Saturate first, then threshold, so large magnitudes binarize as 255.
  logic [OUT_W-1:0] sat, pix_next;
  always_comb begin
    sat      = (s2_scaled > SAT_MAX) ? '1 : s2_scaled[OUT_W-1:0];
    pix_next = sat;
    if (s2_bin_en) begin
      pix_next = (sat >= s2_thresh) ? '1 : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid  <= 1'b0;
      s1_absx   <= '0;
      s1_absy   <= '0;
      s1_cfg    <= '0;
      s2_valid  <= 1'b0;
      s2_scaled <= '0;
      s2_last   <= 1'b0;
      s2_bin_en <= 1'b0;
      s2_thresh <= '0;
      valid_o   <= 1'b0;
      pix_o     <= '0;
      last_o    <= 1'b0;
    end else if (en) begin
      // ready_o == en here, so the input handshake reduces to valid_i.
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_absx       <= abs_x;
        s1_absy       <= abs_y;
        s1_cfg.last   <= last_i;
        s1_cfg.shamt  <= MAG_SHAMT_W'(shamt_i);
        s1_cfg.bin_en <= bin_en_i;
        s1_cfg.thresh <= DEFAULT_OUT_W'(thresh_i);
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_scaled <= scaled;
        s2_last   <= s1_cfg.last;
        s2_bin_en <= s1_cfg.bin_en;
        s2_thresh <= OUT_W'(s1_cfg.thresh);
      end

      valid_o <= s2_valid;
      last_o  <= s2_valid & s2_last;
      if (s2_valid) begin
        pix_o <= pix_next;
      end
    end
  end

endmodule
